// File: rtl/tl_pkg.sv
// TileLink-UL shared constants and packed-bundle geometry.
// Bundles are packed MSB-first with data in the low bits.
package tl_pkg;

    localparam logic [2:0] TL_A_PUT_FULL       = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL    = 3'd1;
    localparam logic [2:0] TL_A_GET            = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK     = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    localparam int OPCODE_W  = 3;
    localparam int A_PARAM_W = 3;
    localparam int D_PARAM_W = 2;
    localparam int D_SINK_W  = 1;

    localparam int DATA_LSB    = 0;
    localparam int A_FIXED_W   = OPCODE_W + A_PARAM_W + 1;
    localparam int D_FIXED_W   = OPCODE_W + D_PARAM_W + D_SINK_W + 2;

    function automatic int a_bits_w(int addr_w, int data_w,
                                    int source_w, int size_w);
        return A_FIXED_W + size_w + source_w + addr_w + data_w / 8 + data_w;
    endfunction

    function automatic int d_bits_w(int data_w, int source_w, int size_w);
        return D_FIXED_W + size_w + source_w + data_w;
    endfunction

    // Field LSBs measured up from the data end of the bundle.
    function automatic int a_mask_lsb(int data_w);
        return data_w + 1;
    endfunction

    function automatic int a_addr_lsb(int data_w);
        return data_w + 1 + data_w / 8;
    endfunction

    function automatic int d_source_lsb(int data_w);
        return data_w + 2 + D_SINK_W;
    endfunction

    function automatic int cnt_w(int depth);
        return (depth > 0) ? $clog2(depth + 1) : 1;
    endfunction

endpackage

// File: rtl/tl_queue.sv
// Valid/ready queue with optional pipe (accept while full and draining)
// and flow (empty bypass); depth 0 is a plain wire.
module tl_queue
    import tl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter bit PIPE  = 1'b0,
    parameter bit FLOW  = 1'b0,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_bits,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_bits,
    output logic [CNT_W-1:0] o_count
);

    if (DEPTH == 0) begin : g_wire
        assign o_in_ready  = i_out_ready;
        assign o_out_valid = i_in_valid;
        assign o_out_bits  = i_in_bits;
        assign o_count     = '0;
    end else begin : g_fifo
        localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
        localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0] r_count;
        logic             w_empty;
        logic             w_full;
        logic             w_enq;
        logic             w_deq;
        logic             w_bypass;
        logic             w_wr;
        logic             w_rd;

        assign w_empty     = (r_count == '0);
        assign w_full      = (r_count == FULL);
        assign o_in_ready  = !w_full || (PIPE && i_out_ready);
        assign o_out_valid = !w_empty || (FLOW && i_in_valid);
        assign o_out_bits  = (FLOW && w_empty) ? i_in_bits : r_mem[r_rptr];

        assign w_enq    = i_in_valid && o_in_ready;
        assign w_deq    = o_out_valid && i_out_ready;
        // A flow beat that leaves as it arrives never touches storage.
        assign w_bypass = FLOW && w_empty && w_deq;
        assign w_wr     = w_enq && !w_bypass;
        assign w_rd     = w_deq && !w_bypass;

        always_ff @(posedge clock) begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_in_bits;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_wr) begin
                    r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
                end
                if (w_rd) begin
                    r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
                end
                if (w_wr && !w_rd) begin
                    r_count <= r_count + 1'b1;
                end else if (w_rd && !w_wr) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end

        assign o_count = r_count;

        a_count_bound: assert property (
            @(posedge clock) disable iff (!reset_n) r_count <= FULL);
        a_bits_stable: assert property (
            @(posedge clock) disable iff (!reset_n)
            (!w_empty && !i_out_ready) |=> $stable(o_out_bits));
    end

endmodule

// File: rtl/tl_ul_channel_buffer.sv
// TileLink-UL A/D channel buffer between a master and a slave port,
// with per-channel occupancy and an idle flag for power control.
module tl_ul_channel_buffer
    import tl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SOURCE_W = 5,
    parameter int SIZE_W   = 4,
    parameter int A_DEPTH  = 2,
    parameter int D_DEPTH  = 2,
    parameter bit A_PIPE   = 1'b0,
    parameter bit A_FLOW   = 1'b0,
    parameter bit D_PIPE   = 1'b0,
    parameter bit D_FLOW   = 1'b0,
    localparam int A_W     = a_bits_w(ADDR_W, DATA_W, SOURCE_W, SIZE_W),
    localparam int D_W     = d_bits_w(DATA_W, SOURCE_W, SIZE_W),
    localparam int A_CNT_W = cnt_w(A_DEPTH),
    localparam int D_CNT_W = cnt_w(D_DEPTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               a_in_valid,
    output logic               a_in_ready,
    input  logic [A_W-1:0]     a_in_bits,
    output logic               a_out_valid,
    input  logic               a_out_ready,
    output logic [A_W-1:0]     a_out_bits,
    input  logic               d_in_valid,
    output logic               d_in_ready,
    input  logic [D_W-1:0]     d_in_bits,
    output logic               d_out_valid,
    input  logic               d_out_ready,
    output logic [D_W-1:0]     d_out_bits,
    output logic [A_CNT_W-1:0] a_count,
    output logic [D_CNT_W-1:0] d_count,
    output logic               idle
);

    logic w_a_empty;
    logic w_d_empty;

    tl_queue #(
        .WIDTH (A_W),
        .DEPTH (A_DEPTH),
        .PIPE  (A_PIPE),
        .FLOW  (A_FLOW)
    ) u_a_queue (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_in_valid  (a_in_valid),
        .o_in_ready  (a_in_ready),
        .i_in_bits   (a_in_bits),
        .o_out_valid (a_out_valid),
        .i_out_ready (a_out_ready),
        .o_out_bits  (a_out_bits),
        .o_count     (a_count)
    );

    tl_queue #(
        .WIDTH (D_W),
        .DEPTH (D_DEPTH),
        .PIPE  (D_PIPE),
        .FLOW  (D_FLOW)
    ) u_d_queue (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_in_valid  (d_in_valid),
        .o_in_ready  (d_in_ready),
        .i_in_bits   (d_in_bits),
        .o_out_valid (d_out_valid),
        .i_out_ready (d_out_ready),
        .o_out_bits  (d_out_bits),
        .o_count     (d_count)
    );

    assign w_a_empty = (a_count == '0);
    assign w_d_empty = (d_count == '0);
    assign idle      = w_a_empty && w_d_empty && !a_in_valid && !d_in_valid;

endmodule

// File: tb/tb_tl_ul_channel_buffer.sv
// Bench for tl_ul_channel_buffer: three configurations checked each
// cycle against a queue-level model plus directed literal expectations.
module tb_tl_ul_channel_buffer;

    localparam int AW = 84;
    localparam int DW = 49;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic cmp_en = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    // ch0/1: u0 A/D, ch2/3: u1 A/D, ch4/5: u2 A/D
    int dep [6] = '{2, 3, 2, 1, 0, 0};
    bit pip [6] = '{0, 0, 0, 1, 0, 0};
    bit flw [6] = '{0, 0, 1, 0, 0, 0};

    logic        iv   [6];
    logic        ordy [6];
    logic [83:0] ib   [6];
    wire         ir   [6];
    wire         ov   [6];
    wire [AW-1:0] oba [3];
    wire [DW-1:0] obd [3];
    wire [1:0]   c0a, c0d, c1a;
    wire [0:0]   c1d, c2a, c2d;
    wire         idle0, idle1, idle2;

    logic [83:0] mq  [6][$];
    logic [31:0] rxq [6][$];

    always #5 clock = ~clock;

    tl_ul_channel_buffer #(.A_DEPTH(2), .D_DEPTH(3)) u0 (
        .clock(clock), .reset_n(reset_n),
        .a_in_valid(iv[0]), .a_in_ready(ir[0]), .a_in_bits(ib[0]),
        .a_out_valid(ov[0]), .a_out_ready(ordy[0]), .a_out_bits(oba[0]),
        .d_in_valid(iv[1]), .d_in_ready(ir[1]), .d_in_bits(ib[1][DW-1:0]),
        .d_out_valid(ov[1]), .d_out_ready(ordy[1]), .d_out_bits(obd[0]),
        .a_count(c0a), .d_count(c0d), .idle(idle0));

    tl_ul_channel_buffer #(.A_DEPTH(2), .A_FLOW(1'b1),
                           .D_DEPTH(1), .D_PIPE(1'b1)) u1 (
        .clock(clock), .reset_n(reset_n),
        .a_in_valid(iv[2]), .a_in_ready(ir[2]), .a_in_bits(ib[2]),
        .a_out_valid(ov[2]), .a_out_ready(ordy[2]), .a_out_bits(oba[1]),
        .d_in_valid(iv[3]), .d_in_ready(ir[3]), .d_in_bits(ib[3][DW-1:0]),
        .d_out_valid(ov[3]), .d_out_ready(ordy[3]), .d_out_bits(obd[1]),
        .a_count(c1a), .d_count(c1d), .idle(idle1));

    tl_ul_channel_buffer #(.A_DEPTH(0), .D_DEPTH(0)) u2 (
        .clock(clock), .reset_n(reset_n),
        .a_in_valid(iv[4]), .a_in_ready(ir[4]), .a_in_bits(ib[4]),
        .a_out_valid(ov[4]), .a_out_ready(ordy[4]), .a_out_bits(oba[2]),
        .d_in_valid(iv[5]), .d_in_ready(ir[5]), .d_in_bits(ib[5][DW-1:0]),
        .d_out_valid(ov[5]), .d_out_ready(ordy[5]), .d_out_bits(obd[2]),
        .a_count(c2a), .d_count(c2d), .idle(idle2));

    function automatic logic [83:0] mk_a(logic [2:0] op, logic [31:0] addr);
        return {op, 3'd0, 4'd2, 5'd3, addr, 4'hf, 1'b0, 32'h0};
    endfunction

    function automatic logic [83:0] mk_d(logic [2:0] op, logic [31:0] data);
        return {35'd0, op, 2'd0, 4'd2, 5'd3, 3'b000, data};
    endfunction

    function automatic logic [31:0] a_addr(logic [83:0] v);
        return v[68:37];
    endfunction

    function automatic logic [83:0] get_ob(int ch);
        case (ch)
            0: return oba[0];
            1: return {35'd0, obd[0]};
            2: return oba[1];
            3: return {35'd0, obd[1]};
            4: return oba[2];
            default: return {35'd0, obd[2]};
        endcase
    endfunction

    function automatic int get_cnt(int ch);
        case (ch)
            0: return int'(c0a);
            1: return int'(c0d);
            2: return int'(c1a);
            3: return int'(c1d);
            4: return int'(c2a);
            default: return int'(c2d);
        endcase
    endfunction

    function automatic bit m_ready(int ch);
        int n = mq[ch].size();
        if (dep[ch] == 0) return ordy[ch];
        return (n < dep[ch]) || (pip[ch] && ordy[ch] && n == dep[ch]);
    endfunction

    function automatic bit m_valid(int ch);
        if (dep[ch] == 0) return iv[ch];
        return (mq[ch].size() > 0) || (flw[ch] && iv[ch]);
    endfunction

    function automatic logic [83:0] m_bits(int ch);
        if (dep[ch] == 0 || mq[ch].size() == 0) return ib[ch];
        return mq[ch][0];
    endfunction

    function automatic bit m_idle(int a);
        return mq[a].size() == 0 && mq[a+1].size() == 0 && !iv[a] && !iv[a+1];
    endfunction

    task automatic check(input string nm, input logic [83:0] act,
                         input logic [83:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) begin
        if (reset_n === 1'b1) begin
            for (int ch = 0; ch < 6; ch++) begin
                bit enq;
                bit deq;
                int n;
                n   = mq[ch].size();
                enq = iv[ch] && m_ready(ch);
                deq = m_valid(ch) && ordy[ch];
                if (dep[ch] > 0) begin
                    if (deq && n > 0) void'(mq[ch].pop_front());
                    if (enq && !(deq && n == 0)) mq[ch].push_back(ib[ch]);
                end
            end
        end
    end

    always @(negedge reset_n) begin
        for (int ch = 0; ch < 6; ch++) mq[ch].delete();
    end

    always @(negedge clock) begin
        if (reset_n === 1'b1 && cmp_en) begin
            for (int ch = 0; ch < 6; ch++) begin
                logic [83:0] v;
                v = get_ob(ch);
                check($sformatf("ch%0d in_ready", ch), ir[ch], m_ready(ch));
                check($sformatf("ch%0d out_valid", ch), ov[ch], m_valid(ch));
                check($sformatf("ch%0d count", ch), get_cnt(ch), mq[ch].size());
                if (m_valid(ch)) check($sformatf("ch%0d out_bits", ch), v, m_bits(ch));
                if (ov[ch] && ordy[ch]) rxq[ch].push_back(v[31:0]);
            end
            check("idle0", idle0, m_idle(0));
            check("idle1", idle1, m_idle(2));
            check("idle2", idle2, m_idle(4));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        bit acc;
        for (int ch = 0; ch < 6; ch++) begin
            iv[ch] = 1'b0;
            ordy[ch] = 1'b0;
            ib[ch] = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        check("rst a_out_valid", ov[0], 1'b0);
        check("rst d_out_valid", ov[1], 1'b0);
        check("rst a_in_ready", ir[0], 1'b1);
        check("rst a_count", get_cnt(0), 0);
        check("rst idle", idle0, 1'b1);
        #2 reset_n = 1'b1;
        cmp_en = 1'b1;

        // two Gets stall in depth-2 A queue, then drain in order
        iv[0] = 1'b1;
        ib[0] = mk_a(tl_pkg::TL_A_GET, 32'h1000);
        tick();
        ib[0] = mk_a(tl_pkg::TL_A_GET, 32'h1004);
        tick();
        iv[0] = 1'b0;
        #1;
        check("a full count", get_cnt(0), 2);
        check("a full in_ready", ir[0], 1'b0);
        check("a head addr", a_addr(oba[0]), 32'h1000);
        ordy[0] = 1'b1;
        tick();
        check("a second addr", a_addr(oba[0]), 32'h1004);
        tick();
        check("a drained valid", ov[0], 1'b0);
        ordy[0] = 1'b0;

        // flow: empty queue forwards in the same cycle
        ordy[2] = 1'b1;
        iv[2] = 1'b1;
        ib[2] = mk_a(tl_pkg::TL_A_GET, 32'h2000);
        #1;
        check("flow out_valid", ov[2], 1'b1);
        check("flow addr", a_addr(oba[1]), 32'h2000);
        check("flow count", get_cnt(2), 0);
        tick();
        check("flow count after", get_cnt(2), 0);
        ordy[2] = 1'b0;
        ib[2] = mk_a(tl_pkg::TL_A_PUT_FULL, 32'h2004);
        tick();
        iv[2] = 1'b0;
        #1;
        check("flow stalled count", get_cnt(2), 1);
        ordy[2] = 1'b1;
        tick();
        ordy[2] = 1'b0;

        // pipe, depth 1: full queue still accepts while draining
        iv[3] = 1'b1;
        ib[3] = mk_d(tl_pkg::TL_D_ACCESS_ACK_DATA, 32'hA0);
        tick();
        check("pipe full in_ready", ir[3], 1'b0);
        ordy[3] = 1'b1;
        #1;
        check("pipe drain in_ready", ir[3], 1'b1);
        for (int k = 1; k <= 4; k++) begin
            ib[3] = mk_d(tl_pkg::TL_D_ACCESS_ACK_DATA, 32'hA0 + k);
            tick();
            check("pipe count", get_cnt(3), 1);
        end
        iv[3] = 1'b0;
        tick();
        ordy[3] = 1'b0;
        check("pipe beats", rxq[3].size(), 5);
        for (int k = 0; k < 5 && k < rxq[3].size(); k++)
            check("pipe order", rxq[3][k], 32'hA0 + k);

        // depth 3: seven beats under random backpressure
        sent = 0;
        for (int cyc = 0; cyc < 300 && (sent < 7 || rxq[1].size() < 7); cyc++) begin
            ordy[1] = 1'($urandom_range(0, 1));
            iv[1] = (sent < 7);
            ib[1] = mk_d(tl_pkg::TL_D_ACCESS_ACK_DATA, 32'(sent));
            #1;
            acc = iv[1] && ir[1];
            tick();
            if (acc) sent++;
        end
        iv[1] = 1'b0;
        ordy[1] = 1'b0;
        check("d3 beats", rxq[1].size(), 7);
        for (int k = 0; k < 7 && k < rxq[1].size(); k++)
            check("d3 order", rxq[1][k], k);

        // depth 0: wire-through
        iv[4] = 1'b1;
        ib[4] = mk_a(tl_pkg::TL_A_PUT_PARTIAL, 32'h3000);
        #1;
        check("wire in_ready lo", ir[4], 1'b0);
        check("wire out_valid", ov[4], 1'b1);
        ordy[4] = 1'b1;
        #1;
        check("wire in_ready hi", ir[4], 1'b1);
        check("wire count", get_cnt(4), 0);
        tick();
        iv[4] = 1'b0;
        ordy[4] = 1'b0;

        // reset in the middle of a burst
        iv[0] = 1'b1;
        iv[1] = 1'b1;
        ib[0] = mk_a(tl_pkg::TL_A_GET, 32'h4000);
        ib[1] = mk_d(tl_pkg::TL_D_ACCESS_ACK, 32'h55);
        tick();
        tick();
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        #1;
        check("pre-rst a_count", get_cnt(0), 2);
        check("pre-rst d_count", get_cnt(1), 2);
        #1 reset_n = 1'b0;
        #1;
        check("mid-rst a_out_valid", ov[0], 1'b0);
        check("mid-rst d_out_valid", ov[1], 1'b0);
        check("mid-rst a_count", get_cnt(0), 0);
        check("mid-rst d_count", get_cnt(1), 0);
        check("mid-rst idle", idle0, 1'b1);
        #10 reset_n = 1'b1;
        tick();
        tick();
        check("post-rst a_out_valid", ov[0], 1'b0);
        check("post-rst d_in_ready", ir[1], 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
